// File: rtl/tow_pkg.sv
// Shared constants for the tug-of-war tick consumers: default channel count,
// default debounce length and the counter-width derivation.
package tow_pkg;

    localparam int NBTN_DEF         = 2;
    localparam int STABLE_TICKS_DEF = 4;

    // Width big enough to hold the value n itself (so 2**w >= n always holds)
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    localparam int CW_DEF = cnt_width(STABLE_TICKS_DEF);

endpackage

// File: rtl/debounce_chan.sv
// One button channel: 2-FF synchroniser, tick-based debounce counter,
// debounced level, one-clk press pulse and sticky press flag with ack.
module debounce_chan
    import tow_pkg::*;
#(
    parameter int STABLE_TICKS = STABLE_TICKS_DEF,
    parameter int CW           = CW_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn_raw,
    input  logic press_ack,
    output logic btn_level,
    output logic btn_press,
    output logic press_pend
);

    localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

    logic          sync1_q, sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          pend_q, pend_d;

    // Next-state: count qualifying ticks while the synced input disagrees with the level
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q == LAST) begin
                level_d = sync2_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        press_d = level_d & ~level_q;
        if (press_d) begin
            pend_d = 1'b1;
        end else if (press_ack) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end
    end

    // State registers, including the synchroniser chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            pend_q  <= pend_d;
        end
    end

    assign btn_level  = level_q;
    assign btn_press  = press_q;
    assign press_pend = pend_q;

endmodule

// File: rtl/tick_debounce.sv
// Debounces NBTN raw push-buttons on the slow tick; wiring only, one
// debounce_chan per button.
module tick_debounce
    import tow_pkg::*;
#(
    parameter int NBTN         = NBTN_DEF,
    parameter int STABLE_TICKS = STABLE_TICKS_DEF,
    parameter int CW           = cnt_width(STABLE_TICKS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick,
    input  logic [NBTN-1:0] btn_raw,
    output logic [NBTN-1:0] btn_level,
    output logic [NBTN-1:0] btn_press,
    output logic [NBTN-1:0] press_pend,
    input  logic [NBTN-1:0] press_ack
);

    for (genvar i = 0; i < NBTN; i++) begin : g_chan
        debounce_chan #(
            .STABLE_TICKS(STABLE_TICKS),
            .CW          (CW)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .tick      (tick),
            .btn_raw   (btn_raw[i]),
            .press_ack (press_ack[i]),
            .btn_level (btn_level[i]),
            .btn_press (btn_press[i]),
            .press_pend(press_pend[i])
        );
    end

endmodule

// File: tb/tb_tick_debounce.sv
// Randomised bench for tick_debounce, checked every clock against a
// reference model that applies the debounce rules directly.
module tb_tick_debounce;

    localparam int NBTN = 2;
    localparam int ST   = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            tick;
    logic [NBTN-1:0] btn_raw;
    logic [NBTN-1:0] btn_level;
    logic [NBTN-1:0] btn_press;
    logic [NBTN-1:0] press_pend;
    logic [NBTN-1:0] press_ack;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: raw history stands in for synchroniser latency,
    // run[] is the number of ticks seen in the current disagreeing run
    logic [NBTN-1:0] hist1, hist2;
    logic [NBTN-1:0] m_level, m_press, m_pend;
    int              run [NBTN];

    // Per-channel stimulus state: base level, cycles left to hold it
    logic [NBTN-1:0] base;
    int              hold [NBTN];

    tick_debounce #(.NBTN(NBTN), .STABLE_TICKS(ST)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .btn_raw   (btn_raw),
        .btn_level (btn_level),
        .btn_press (btn_press),
        .press_pend(press_pend),
        .press_ack (press_ack)
    );

    // Free-running 100 MHz-style clock
    always #5 clk = ~clk;

    // Single comparison point: counts and reports a mismatch
    task automatic checkOutput(input string tag, input logic [NBTN-1:0] got,
                               input logic [NBTN-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %b expected %b", tag, cyc, got, exp);
        end
    endtask

    // Clear the model exactly as reset clears the hardware
    task automatic modelReset();
        hist1   = '0;
        hist2   = '0;
        m_level = '0;
        m_press = '0;
        m_pend  = '0;
        for (int c = 0; c < NBTN; c++) run[c] = 0;
    endtask

    // Advance the model by one clock using the inputs held before the edge
    task automatic modelEdge();
        logic [NBTN-1:0] s;
        s       = hist2;
        hist2   = hist1;
        hist1   = btn_raw;
        m_press = '0;
        for (int c = 0; c < NBTN; c++) begin
            if (s[c] == m_level[c]) begin
                run[c] = 0;
            end else if (tick) begin
                run[c] = run[c] + 1;
                if (run[c] == ST) begin
                    m_level[c] = s[c];
                    run[c]     = 0;
                    if (s[c]) m_press[c] = 1'b1;
                end
            end
            if (m_press[c])        m_pend[c] = 1'b1;
            else if (press_ack[c]) m_pend[c] = 1'b0;
        end
    endtask

    // Compare all outputs against the model
    task automatic compareAll();
        checkOutput("btn_level", btn_level, m_level);
        checkOutput("btn_press", btn_press, m_press);
        checkOutput("press_pend", press_pend, m_pend);
    endtask

    // Asynchronous reset pulse placed between edges; outputs must clear at once
    task automatic rstPulse();
        rst = 1'b1;
        modelReset();
        #1;
        compareAll();
        @(posedge clk);
        #1;
        compareAll();
        rst = 1'b0;
    endtask

    // Drive random button activity for a number of clocks.
    // period: tick spacing (1 = tick tied high); hold_max 0 freezes buttons;
    // bounce/ack/rst chances are per mille per clock.
    task automatic applyStimulus(input int cycles, input int period, input int hold_max,
                                 input int bounce_pm, input int ack_pm, input int rst_pm);
        logic [NBTN-1:0] glitch;
        for (int n = 0; n < cycles; n++) begin
            tick   = (period == 1) ? 1'b1 : ((cyc % period) == 0);
            glitch = '0;
            for (int c = 0; c < NBTN; c++) begin
                if (hold_max > 0) begin
                    if (hold[c] <= 0) begin
                        base[c] = ~base[c];
                        hold[c] = $urandom_range(hold_max, 1);
                    end else begin
                        hold[c] = hold[c] - 1;
                    end
                    if ($urandom_range(999, 0) < bounce_pm) glitch[c] = 1'b1;
                end
                press_ack[c] = ($urandom_range(999, 0) < ack_pm);
            end
            btn_raw = base ^ glitch;
            @(posedge clk);
            cyc++;
            modelEdge();
            #1;
            compareAll();
            if ($urandom_range(999, 0) < rst_pm) rstPulse();
        end
    endtask

    // Test sequence: directed reset-held case, then random phases
    initial begin
        rst       = 1'b1;
        tick      = 1'b0;
        btn_raw   = 2'b11;
        press_ack = '0;
        base      = 2'b11;
        for (int c = 0; c < NBTN; c++) hold[c] = 0;
        modelReset();
        #12;
        compareAll();
        @(negedge clk);
        rst = 1'b0;

        // Buttons held through reset: accepted only after fresh ticks
        applyStimulus(80, 8, 0, 0, 0, 0);
        $display("[TB] held-through-reset phase done, level=%b pend=%b", btn_level, press_pend);
        checkOutput("held_level", btn_level, 2'b11);
        checkOutput("held_pend", press_pend, 2'b11);

        // Ack both, then tick tied high, then slow ticks with long holds
        applyStimulus(4, 8, 0, 0, 1000, 0);
        checkOutput("acked_pend", press_pend, 2'b00);
        applyStimulus(3000, 1, 12, 30, 20, 0);
        applyStimulus(6000, 16, 200, 10, 5, 1);
        applyStimulus(4000, 4, 60, 40, 1000, 0);
        applyStimulus(6000, 8, 120, 20, 50, 2);
        applyStimulus(3000, 1, 6, 100, 100, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net against a stalled run
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

endmodule
